trace_input_frontend: RTL

- Parametrised trace-pin front end for the trace capture path; replaces fixed board-revision pin muxing with per-lane programmable pin selection from trace pins or user I/O.
- Supports 1/2/4-lane parallel trace modes and a programmable SWO source.
- Contains a TPIU full-sync detector, an idle-line detector and a clock-alive heartbeat.
- Sits between the package pins and the trace decoder/capture logic; all configuration inputs come from the USB register block and are already synchronised to trace_clk.

---
 rtl/trace_input_frontend_if.sv | 34 +++
 rtl/trace_input_frontend.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/trace_input_frontend_if.sv
// Pin, configuration and status bundle between the trace pins/register block
// and the trace input front end.
interface trace_input_frontend_if #(
  parameter int pMAX_WIDTH    = 4,
  parameter int pUSERIO_WIDTH = 4,
  parameter int pSEL_WIDTH    = 3,
  parameter int pIDLE_BITS    = 16
);
  logic [pMAX_WIDTH-1:0]            trace_pins;
  logic [pUSERIO_WIDTH-1:0]         userio_pins;
  logic [pMAX_WIDTH*pSEL_WIDTH-1:0] cfg_lane_sel;
  logic [pSEL_WIDTH-1:0]            cfg_swo_sel;
  logic [1:0]                       cfg_port_width;
  logic [pIDLE_BITS-1:0]            cfg_idle_limit;
  logic                             cfg_resync;
  logic [pMAX_WIDTH-1:0]            trace_data_o;
  logic                             swo_o;
  logic                             synchronized_o;
  logic [1:0]                       sync_lane_o;
  logic                             idle_o;
  logic                             heartbeat_o;

  modport master (
    output trace_pins, userio_pins, cfg_lane_sel, cfg_swo_sel,
           cfg_port_width, cfg_idle_limit, cfg_resync,
    input  trace_data_o, swo_o, synchronized_o, sync_lane_o, idle_o, heartbeat_o
  );

  modport slave (
    input  trace_pins, userio_pins, cfg_lane_sel, cfg_swo_sel,
           cfg_port_width, cfg_idle_limit, cfg_resync,
    output trace_data_o, swo_o, synchronized_o, sync_lane_o, idle_o, heartbeat_o
  );
endinterface

// File: rtl/trace_input_frontend.sv
// Trace pin front end: programmable lane/SWO source muxing, width masking,
// TPIU full-sync detection, idle-line detection and a clock-alive heartbeat.
module trace_input_frontend #(
  parameter int pMAX_WIDTH      = 4,
  parameter int pUSERIO_WIDTH   = 4,
  parameter int pSEL_WIDTH      = 3,
  parameter int pIDLE_BITS      = 16,
  parameter int pHEARTBEAT_BITS = 23
) (
  input  logic                  trace_clk,
  input  logic                  reset,
  trace_input_frontend_if.slave tif
);
  localparam int NSRC = pMAX_WIDTH + pUSERIO_WIDTH;
  localparam int NPAD = 1 << pSEL_WIDTH;

  logic [pMAX_WIDTH-1:0]      trace_s1_reg;
  logic [pUSERIO_WIDTH-1:0]   userio_s1_reg;
  logic [pMAX_WIDTH-1:0]      trace_data_reg;
  logic [pMAX_WIDTH-1:0]      trace_data_next;
  logic                       swo_reg;
  logic                       swo_next;
  logic [pMAX_WIDTH-1:0]      prev_data_reg;
  logic [pIDLE_BITS-1:0]      idle_cnt_reg;
  logic                       idle_d_reg;
  logic                       idle_now;
  logic [1:0]                 port_width_reg;
  logic [pHEARTBEAT_BITS-1:0] heartbeat_reg;
  logic [5:0]                 ones_cnt_reg;
  logic [5:0]                 ones_cnt_next;
  logic                       sync_reg;
  logic [1:0]                 sync_lane_reg;

  logic [2:0]            active_w;
  logic [pMAX_WIDTH-1:0] lane_en;
  logic [NSRC-1:0]       src_vec;
  logic [NPAD-1:0]       src_pad;

  // Sources beyond the real pins are zero in the padded vector, so an
  // out-of-range select naturally reads 0.
  assign src_vec = {userio_s1_reg, trace_s1_reg};
  assign src_pad = NPAD'(src_vec);

  always_comb begin
    active_w = 3'd4;
    case (tif.cfg_port_width)
      2'd0:    active_w = 3'd1;
      2'd1:    active_w = 3'd2;
      default: active_w = 3'd4;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < pMAX_WIDTH; gi++) begin : g_lane
      logic [pSEL_WIDTH-1:0] lane_sel;
      assign lane_sel            = tif.cfg_lane_sel[gi*pSEL_WIDTH +: pSEL_WIDTH];
      assign lane_en[gi]         = (active_w > 3'(gi));
      assign trace_data_next[gi] = lane_en[gi] & src_pad[lane_sel];
    end
  endgenerate

  assign swo_next = src_pad[tif.cfg_swo_sel];

  // Sync detector: lane 0 is the earliest bit, so the terminating zero is the
  // lowest active zero lane and the new run starts at the highest lane.
  logic       all_ones;
  logic       zero_seen;
  logic [1:0] z_idx;
  logic [5:0] tail_cnt;
  logic       tail_run;
  logic [6:0] run_sum;
  logic [6:0] term_sum;
  logic       sync_detect;
  logic       sync_clear;

  always_comb begin
    all_ones  = 1'b1;
    zero_seen = 1'b0;
    z_idx     = 2'd0;
    tail_cnt  = 6'd0;
    tail_run  = 1'b1;
    for (int i = 0; i < pMAX_WIDTH; i++) begin
      if (lane_en[i] && !trace_data_reg[i]) begin
        all_ones = 1'b0;
        if (!zero_seen) begin
          zero_seen = 1'b1;
          z_idx     = 2'(i);
        end
      end
    end
    for (int i = pMAX_WIDTH - 1; i >= 0; i--) begin
      if (lane_en[i]) begin
        if (tail_run && trace_data_reg[i]) tail_cnt = tail_cnt + 6'd1;
        else                               tail_run = 1'b0;
      end
    end
    run_sum     = {1'b0, ones_cnt_reg} + 7'(active_w);
    term_sum    = {1'b0, ones_cnt_reg} + 7'(z_idx);
    sync_detect = !all_ones && (term_sum >= 7'd31);
    if (all_ones) ones_cnt_next = (run_sum > 7'd63) ? 6'd63 : run_sum[5:0];
    else          ones_cnt_next = tail_cnt;
  end

  assign idle_now   = (tif.cfg_idle_limit != '0) && (idle_cnt_reg >= tif.cfg_idle_limit);
  assign sync_clear = tif.cfg_resync || (idle_now && !idle_d_reg) ||
                      (tif.cfg_port_width != port_width_reg);

  always_ff @(posedge trace_clk) begin
    if (reset) begin
      trace_s1_reg   <= '0;
      userio_s1_reg  <= '0;
      trace_data_reg <= '0;
      swo_reg        <= 1'b0;
      prev_data_reg  <= '0;
      idle_cnt_reg   <= '0;
      idle_d_reg     <= 1'b0;
      port_width_reg <= 2'd0;
      heartbeat_reg  <= '0;
      ones_cnt_reg   <= 6'd0;
      sync_reg       <= 1'b0;
      sync_lane_reg  <= 2'd0;
    end else begin
      trace_s1_reg   <= tif.trace_pins;
      userio_s1_reg  <= tif.userio_pins;
      trace_data_reg <= trace_data_next;
      swo_reg        <= swo_next;
      prev_data_reg  <= trace_data_reg;
      idle_d_reg     <= idle_now;
      port_width_reg <= tif.cfg_port_width;
      heartbeat_reg  <= heartbeat_reg + 1'b1;

      if (trace_data_reg != prev_data_reg) idle_cnt_reg <= '0;
      else if (idle_cnt_reg != '1)         idle_cnt_reg <= idle_cnt_reg + 1'b1;

      if (sync_clear) begin
        sync_reg     <= 1'b0;
        ones_cnt_reg <= 6'd0;
      end else begin
        ones_cnt_reg <= ones_cnt_next;
        if (sync_detect) begin
          sync_reg      <= 1'b1;
          sync_lane_reg <= z_idx;
        end
      end
    end
  end

  assign tif.trace_data_o   = trace_data_reg;
  assign tif.swo_o          = swo_reg;
  assign tif.synchronized_o = sync_reg;
  assign tif.sync_lane_o    = sync_lane_reg;
  assign tif.idle_o         = idle_now;
  assign tif.heartbeat_o    = heartbeat_reg[pHEARTBEAT_BITS-1];
endmodule
